// File: rtl/core_cf_redirect_arb_pkg.sv
// Shared encodings for the fetch-redirect arbiter.
// State and owner codes are kept as plain 2-bit constants for legacy tools.
package core_cf_redirect_arb_pkg;

  localparam int CFARB_XL = 63;

  localparam logic [1:0] CFARB_BOOT = 2'd0;
  localparam logic [1:0] CFARB_IDLE = 2'd1;
  localparam logic [1:0] CFARB_BUSY = 2'd2;

  localparam logic [1:0] CFARB_OWN_NONE = 2'd0;
  localparam logic [1:0] CFARB_OWN_BOOT = 2'd1;
  localparam logic [1:0] CFARB_OWN_WB   = 2'd2;
  localparam logic [1:0] CFARB_OWN_EX   = 2'd3;

endpackage

// File: rtl/core_cf_redirect_arb.sv
// Serialises boot, WB and EX redirects onto the single fetch redirect bus.
// A latched redirect is held until fetch acks; WB beats EX when sampling.
module core_cf_redirect_arb
  import core_cf_redirect_arb_pkg::*;
#(
  parameter int          XL        = CFARB_XL,
  parameter logic [63:0] BOOT_ADDR = 64'h0
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        wb_cf_valid,
  input  logic [XL:0] wb_cf_target,
  output logic        wb_cf_ack,
  input  logic        ex_cf_valid,
  input  logic [XL:0] ex_cf_target,
  output logic        ex_cf_ack,
  output logic        ex_kill,
  output logic        cf_valid,
  output logic [XL:0] cf_target,
  input  logic        cf_ack,
  output logic        busy
);

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [1:0]  owner_q;
  logic [1:0]  owner_d;
  logic [XL:0] tgt_q;
  logic [XL:0] tgt_d;

  logic ack_cyc;
  logic can_take;
  logic wb_take;
  logic ex_take;
  logic done;

  assign cf_valid  = (state_q != CFARB_IDLE);
  assign cf_target = tgt_q;
  assign busy      = cf_valid;

  assign wb_cf_ack = cf_ack && (owner_q == CFARB_OWN_WB);
  assign ex_cf_ack = cf_ack && (owner_q == CFARB_OWN_EX);

  // The current owner's valid is stale in its own ack cycle.
  assign ack_cyc  = cf_ack && cf_valid;
  assign can_take = (state_q == CFARB_IDLE) || ack_cyc;
  assign wb_take  = can_take && wb_cf_valid
                 && (owner_q != CFARB_OWN_WB);
  assign ex_take  = can_take && ex_cf_valid
                 && (owner_q != CFARB_OWN_EX)
                 && !wb_take;
  assign done     = ack_cyc && !wb_take && !ex_take;

  assign ex_kill  = wb_take;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    tgt_d   = tgt_q;
    unique case (1'b1)
      wb_take: begin
        state_d = CFARB_BUSY;
        owner_d = CFARB_OWN_WB;
        tgt_d   = wb_cf_target;
      end
      ex_take: begin
        state_d = CFARB_BUSY;
        owner_d = CFARB_OWN_EX;
        tgt_d   = ex_cf_target;
      end
      done: begin
        state_d = CFARB_IDLE;
        owner_d = CFARB_OWN_NONE;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= CFARB_BOOT;
      owner_q <= CFARB_OWN_BOOT;
      tgt_q   <= BOOT_ADDR[XL:0];
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_core_cf_redirect_arb.sv
// Directed and random checks of the redirect arbiter against a
// transaction-level model: a one-deep queue of outstanding redirects.
module tb_core_cf_redirect_arb;

  localparam logic [63:0] BOOT = 64'h0000_0000_0000_1000;
  localparam int S_NONE = 0;
  localparam int S_BOOT = 1;
  localparam int S_WB   = 2;
  localparam int S_EX   = 3;

  typedef struct {
    int          src;
    logic [63:0] tgt;
  } rq_t;

  logic        g_clk;
  logic        g_resetn;
  logic        wb_cf_valid;
  logic [63:0] wb_cf_target;
  logic        wb_cf_ack;
  logic        ex_cf_valid;
  logic [63:0] ex_cf_target;
  logic        ex_cf_ack;
  logic        ex_kill;
  logic        cf_valid;
  logic [63:0] cf_target;
  logic        cf_ack;
  logic        busy;

  int total = 0;
  int bad   = 0;

  rq_t         q[$];
  logic [63:0] m_tgt;
  bit          m_known = 0;
  bit          l_wback;
  bit          l_exack;
  bit          l_kill;

  core_cf_redirect_arb #(
    .XL(63),
    .BOOT_ADDR(BOOT)
  ) dut (
    .g_clk(g_clk),
    .g_resetn(g_resetn),
    .wb_cf_valid(wb_cf_valid),
    .wb_cf_target(wb_cf_target),
    .wb_cf_ack(wb_cf_ack),
    .ex_cf_valid(ex_cf_valid),
    .ex_cf_target(ex_cf_target),
    .ex_cf_ack(ex_cf_ack),
    .ex_kill(ex_kill),
    .cf_valid(cf_valid),
    .cf_target(cf_target),
    .cf_ack(cf_ack),
    .busy(busy)
  );

  initial g_clk = 0;
  always #5 g_clk = ~g_clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Evaluate one cycle: check outputs, then advance the model on the edge.
  task automatic cyc();
    bit e_valid;
    int cur;
    bit open;
    bit take_wb;
    bit take_ex;
    #1;
    e_valid = (q.size() != 0);
    cur     = e_valid ? q[0].src : S_NONE;
    l_wback = cf_ack && cur == S_WB;
    l_exack = cf_ack && cur == S_EX;
    open    = !e_valid || cf_ack;
    take_wb = open && wb_cf_valid && !(cf_ack && cur == S_WB);
    take_ex = open && ex_cf_valid && cur != S_EX && !take_wb;
    l_kill  = take_wb;
    if (m_known) begin
      chk("cf_valid", {63'd0, cf_valid}, {63'd0, e_valid});
      chk("busy", {63'd0, busy}, {63'd0, e_valid});
      chk("cf_target", cf_target, m_tgt);
      chk("wb_cf_ack", {63'd0, wb_cf_ack}, {63'd0, l_wback});
      chk("ex_cf_ack", {63'd0, ex_cf_ack}, {63'd0, l_exack});
      chk("ex_kill", {63'd0, ex_kill}, {63'd0, l_kill});
    end
    @(posedge g_clk);
    if (!g_resetn) begin
      q.delete();
      q.push_back('{S_BOOT, BOOT});
      m_tgt   = BOOT;
      m_known = 1;
    end else if (m_known) begin
      if (e_valid && cf_ack) void'(q.pop_front());
      if (take_wb) begin
        q.push_back('{S_WB, wb_cf_target});
        m_tgt = wb_cf_target;
      end else if (take_ex) begin
        q.push_back('{S_EX, ex_cf_target});
        m_tgt = ex_cf_target;
      end
    end
    @(negedge g_clk);
  endtask

  initial begin
    g_resetn     = 0;
    wb_cf_valid  = 0;
    wb_cf_target = '0;
    ex_cf_valid  = 0;
    ex_cf_target = '0;
    cf_ack       = 0;
    @(negedge g_clk);
    cyc();
    cyc();
    g_resetn = 1;
    repeat (3) cyc();
    chk("boot_hold_tgt", cf_target, BOOT);
    cf_ack = 1;
    cyc();
    cf_ack = 0;
    cyc();
    chk("boot_idle", {63'd0, cf_valid}, 64'd0);

    ex_cf_valid  = 1;
    ex_cf_target = 64'h80;
    cf_ack       = 1;
    cyc();
    chk("ex_tgt", cf_target, 64'h80);
    cyc();
    ex_cf_valid = 0;
    cyc();
    cf_ack = 0;

    wb_cf_valid  = 1;
    wb_cf_target = 64'h100;
    ex_cf_valid  = 1;
    ex_cf_target = 64'h80;
    cyc();
    chk("wb_prio_tgt", cf_target, 64'h100);
    ex_cf_valid = 0;
    cf_ack      = 1;
    cyc();
    wb_cf_valid = 0;
    cf_ack      = 0;
    repeat (2) cyc();

    ex_cf_valid  = 1;
    ex_cf_target = 64'h80;
    cyc();
    cyc();
    wb_cf_valid  = 1;
    wb_cf_target = 64'h200;
    repeat (2) cyc();
    chk("hold_tgt", cf_target, 64'h80);
    cf_ack = 1;
    cyc();
    chk("b2b_tgt", cf_target, 64'h200);
    chk("b2b_valid", {63'd0, cf_valid}, 64'd1);
    ex_cf_valid = 0;
    cf_ack      = 0;
    cyc();
    cf_ack = 1;
    cyc();
    wb_cf_valid = 0;
    cf_ack      = 0;
    cyc();

    wb_cf_valid  = 1;
    wb_cf_target = 64'h300;
    cyc();
    g_resetn    = 0;
    wb_cf_valid = 0;
    cyc();
    g_resetn = 1;
    chk("rst_tgt", cf_target, BOOT);
    cyc();
    cf_ack = 1;
    cyc();
    cf_ack = 0;
    cyc();

    cf_ack = 1;
    cyc();
    cf_ack = 0;
    cyc();
    chk("idle_ack_ignored", {63'd0, cf_valid}, 64'd0);

    for (int i = 0; i < 600; i++) begin
      if (!wb_cf_valid && $urandom_range(0, 5) == 0) begin
        wb_cf_valid  = 1;
        wb_cf_target = {$urandom(), $urandom()};
      end
      if (!ex_cf_valid && $urandom_range(0, 3) == 0) begin
        ex_cf_valid  = 1;
        ex_cf_target = {$urandom(), $urandom()};
      end
      cf_ack   = 1'($urandom_range(0, 1));
      g_resetn = ($urandom_range(0, 99) != 0);
      cyc();
      if (l_wback) wb_cf_valid = 0;
      if (l_exack || l_kill) ex_cf_valid = 0;
      if (!g_resetn) begin
        wb_cf_valid = 0;
        ex_cf_valid = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
